// File: rtl/add_seq_if.sv
// Handshake/result bundle for the nibble-serial adder.
// master drives start/sub/op_a/op_b; slave returns busy/done/result/carry/overflow.
interface add_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;

  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, result, carry, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, result, carry, overflow
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Nibble-serial add/subtract sequencer driving an external 4-bit full adder.
// Ports: clk, rst (sync, active-high), bus (add_seq_if.slave), fa_* adder link.
module add_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  add_seq_if.slave   bus,
  output logic [3:0] fa_a,
  output logic [3:0] fa_b,
  output logic       fa_c_in,
  input  logic [3:0] fa_s,
  input  logic       fa_c_out
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          sub_q;
  logic          carry_q;
  logic [W-1:0]  result_q;
  logic          carry_o;
  logic          ovf_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (idx == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B slices are inverted and
  // the initial carry is seeded with sub.
  always_comb begin
    fa_a    = '0;
    fa_b    = '0;
    fa_c_in = 1'b0;
    if (state == RUN) begin
      fa_a    = a_q[4*idx +: 4];
      fa_b    = b_q[4*idx +: 4] ^ {4{sub_q}};
      fa_c_in = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      carry_o  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            sub_q   <= bus.sub;
            carry_q <= bus.sub;
            idx     <= '0;
          end
        end
        RUN: begin
          result_q[4*idx +: 4] <= fa_s;
          carry_q              <= fa_c_out;
          if (idx == LAST) begin
            carry_o <= fa_c_out;
            // fa_a[3]/fa_b[3] are the operand sign bits on the MSB slice.
            ovf_q   <= (fa_a[3] == fa_b[3]) && (fa_s[3] != fa_a[3]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.result   = result_q;
  assign bus.carry    = carry_o;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl with a behavioural full_adder4.
// Stimulus pushes expected results; a negedge monitor pops on done.
module tb_add_seq_ctrl;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fa_a;
  logic [3:0] fa_b;
  logic       fa_c_in;
  logic [3:0] fa_s;
  logic       fa_c_out;
  int         cyc = 0;
  int         pass_cnt = 0;
  int         tot_cnt = 0;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        v;
    int          at;
  } exp_t;

  exp_t q[$];

  add_seq_if #(.NIBBLES(N)) bus ();

  add_seq_ctrl #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_c_in  (fa_c_in),
    .fa_s     (fa_s),
    .fa_c_out (fa_c_out)
  );

  assign {fa_c_out, fa_s} = 5'(fa_a) + 5'(fa_b) + 5'(fa_c_in);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      chk("done_fa_zero", {fa_a, fa_b, fa_c_in}, 0);
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", cyc, e.at);
        chk("result", bus.result, e.r);
        chk("carry", bus.carry, e.c);
        chk("overflow", bus.overflow, e.v);
      end
    end
  end

  // Caller must be just past a negedge with the DUT idle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] er,
                       input logic ec, input logic ev,
                       output logic [3:0] cins);
    chk("idle_fa_zero", {fa_a, fa_b, fa_c_in}, 0);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.sub   = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("accept", bus.busy, 1);
    q.push_back('{er, ec, ev, cyc + N});
    bus.op_a = 16'hDEAD;
    bus.op_b = 16'hBEEF;
    bus.sub  = ~s;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      cins[i] = fa_c_in;
    end
    for (int k = 0; k < 10 && bus.busy; k++) @(negedge clk);
    chk("drain", bus.busy, 0);
    chk("hold", bus.result, er);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] ci;
    int         t0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",
        {bus.busy, bus.done, bus.result, bus.carry, bus.overflow}, 0);
    chk("rst_fa", {fa_a, fa_b, fa_c_in}, 0);

    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, ci);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, ci);
    chk("cin_ffff", ci, 4'hE);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, ci);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, ci);
    chk("cin_sub", ci, 4'h1);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, ci);
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, ci);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, ci);
    do_op(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, ci);

    // start held high with operands churning while busy
    bus.op_a  = 16'h0010;
    bus.op_b  = 16'h0020;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    q.push_back('{16'h0030, 1'b0, 1'b0, cyc + N});
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 6) begin
        bus.op_a = 16'h0100;
        bus.op_b = 16'h0011;
        bus.sub  = 1'b0;
      end else begin
        bus.op_a = 16'(j * 16'h1111);
        bus.op_b = 16'(j * 16'h0F0F);
        bus.sub  = j[0];
      end
    end
    @(posedge clk);
    #1;
    chk("reaccept_busy", bus.busy, 1);
    chk("reaccept_gap", cyc - t0, N + 2);
    q.push_back('{16'h0111, 1'b0, 1'b0, cyc + N});
    bus.start = 1'b0;
    for (int k = 0; k < 12 && (bus.busy || q.size() != 0); k++)
      @(negedge clk);
    chk("held_drain", q.size(), 0);

    // reset while RUN at idx=2
    @(negedge clk);
    bus.op_a  = 16'h1111;
    bus.op_b  = 16'h2222;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out",
        {bus.busy, bus.done, bus.result, bus.carry, bus.overflow}, 0);
    chk("midrst_fa", {fa_a, fa_b, fa_c_in}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 2) @(negedge clk);
    do_op(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, ci);

    repeat (5) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES (16 at default).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request to begin one add/subtract; sampled only in IDLE.
REQ-005 sub  in  1  0 = A+B, 1 = A-B; latched with start.
REQ-006 op_a  in  W  operand A; latched with start.
REQ-007 op_b  in  W  operand B; latched with start.
REQ-008 busy  out  1  high in RUN and DONE.
REQ-009 done  out  1  one-cycle pulse; result, carry and overflow are valid.
REQ-010 result  out  W  sum/difference.
REQ-011 carry  out  1  final carry out of MSB slice (for sub: 1 = no borrow).
REQ-012 overflow  out  1  two's-complement signed overflow.
REQ-013 fa_a  out  4  A slice to external full_adder4 .a.
REQ-014 fa_b  out  4  effective B slice to full_adder4 .b.
REQ-015 fa_c_in  out  1  carry to full_adder4 .c_in.
REQ-016 fa_s  in  4  full_adder4 .s (combinational from fa_a/fa_b/fa_c_in).
REQ-017 fa_c_out  in  1  full_adder4 .c_out.

Function
REQ-018 States: IDLE, RUN, DONE; a slice index idx counts 0..NIBBLES-1.
REQ-019 IDLE & start=1: latch op_a, op_b, sub; idx<=0; carry_reg<=sub; go RUN. IDLE & start=0: stay.
REQ-020 RUN, combinational: fa_a = A[4*idx+3:4*idx]; fa_b = B slice, bitwise inverted when sub=1; fa_c_in = carry_reg.
REQ-021 RUN, each edge: result slice idx <= fa_s; carry_reg <= fa_c_out; idx<=idx+1; at idx=NIBBLES-1 go DONE instead of incrementing.
REQ-022 Entering DONE: carry <= fa_c_out of last slice; overflow <= (A[W-1] == Beff[W-1]) && (fa_s[3] != A[W-1]), with Beff = B inverted when sub=1.
REQ-023 DONE lasts exactly one cycle with done=1, then IDLE unconditionally.
REQ-024 Latency: start accepted at edge N -> done high during cycle N+NIBBLES+1 (cycle N+5 at default); throughput one operation per NIBBLES+2 cycles.
REQ-025 start in RUN or DONE is ignored, not queued; inputs changing while busy do not affect the operation.
REQ-026 In IDLE and DONE, fa_a, fa_b, fa_c_in are driven 0.
REQ-027 result, carry, overflow hold their last value from DONE until next accepted start; result slices are overwritten progressively during RUN.
REQ-028 Carry wraps out of the MSB; result is modulo 2^W, never widened.

Reset
REQ-029 rst=1 at a clock edge forces IDLE, idx=0, carry_reg=0, busy=0, done=0, result=0, carry=0, overflow=0, fa_*=0.
REQ-030 rst overrides start on the same edge; reset during RUN or DONE abandons the operation with no done pulse.
REQ-031 First start accepted on the first edge with rst=0.

Verification
REQ-032 A=0x0002, B=0x0003, sub=0 -> done at start+5 cycles, result=0x0005, carry=0, overflow=0.
REQ-033 A=0xFFFF, B=0x0001, sub=0 -> result=0x0000, carry=1, overflow=0; fa_c_in=1 on slices 1-3.
REQ-034 A=0x7FFF, B=0x0001, sub=0 -> result=0x8000, carry=0, overflow=1.
REQ-035 A=0x0005, B=0x0007, sub=1 -> result=0xFFFE, carry=0, overflow=0; A=0x8000, B=0x0001, sub=1 -> result=0x7FFF, carry=1, overflow=1.
REQ-036 start held high continuously with changing operands -> only the operands at the accepting edge are used; next acceptance exactly NIBBLES+2 cycles later.
REQ-037 rst pulsed at RUN idx=2 -> no done, all outputs 0 next cycle; subsequent 2+3 completes correctly.
